// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: RMII line symbols, CRC-32 constants,
// frame length limits and the receive state encoding.
//
// CRC convention: the CRC register is kept in reflected (LSB-first, right
// shifting) form and is never complemented. After the whole frame including
// the FCS has been shifted in, a good frame leaves the register at
// 0xDEBB20E3, which is the value CRC32_RESIDUE holds.
package eth_pkg;

  // RMII line symbols, dibit = {RXD[1], RXD[0]}
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;
  localparam logic [1:0] PREDATA_DIBIT  = 2'b00;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam int unsigned ETH_MIN_FRAME = 64;
  localparam int unsigned ETH_MAX_FRAME = 1518;

  // Byte counter width and its saturation value
  localparam int unsigned   LEN_W   = 11;
  localparam logic [LEN_W-1:0] LEN_SAT = 11'd2047;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StData
  } rx_state_e;

  // Next reflected CRC after shifting in one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = {1'b0, c[31:1]} ^ ((c[0] ^ d[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d2.sv
// CRC-32 engine advancing two bits per clock.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, loads CRC32_INIT
//   init   load CRC32_INIT (takes priority over en)
//   en     shift in one dibit
//   dibit  data dibit, bit 0 is shifted first
//   crc    current CRC register (reflected, not complemented)
module crc32_d2
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc32_dibit(crc, dibit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC32_INIT;
    end else if (init) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/rmii_rx_mac.sv
// RMII 100 Mb/s receive MAC front end. Strips preamble/SFD, assembles bytes,
// counts length and checks the FCS, delivering a byte stream with SOF/EOF
// strobes and per-frame status.
//
// Ports:
//   clk_50MHz     RMII reference clock
//   rst           synchronous active-high reset
//   CRS, RX1, RX0 RMII CRS_DV and RXD[1:0] from the PHY
//   rx_data       received byte, first dibit in bits [1:0]
//   rx_valid      one-cycle byte strobe
//   rx_sof        with rx_valid on the first byte of a frame
//   rx_eof        one-cycle end-of-frame strobe, never with rx_valid
//   rx_len        frame byte count including FCS (valid with rx_eof)
//   rx_crc_ok     FCS residue matched (valid with rx_eof)
//   rx_len_err    length outside MIN/MAX (valid with rx_eof)
//   rx_align_err  frame ended off a byte boundary (valid with rx_eof)
module rmii_rx_mac
  import eth_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE_DIBITS = 8,
  parameter int unsigned MIN_FRAME_BYTES     = ETH_MIN_FRAME,
  parameter int unsigned MAX_FRAME_BYTES     = ETH_MAX_FRAME
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             CRS,
  input  logic             RX0,
  input  logic             RX1,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_crc_ok,
  output logic             rx_len_err,
  output logic             rx_align_err
);

  localparam logic [7:0]       MIN_PRE = 8'(MIN_PREAMBLE_DIBITS);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  // Registered line inputs
  logic       crs_q;
  logic [1:0] dib_q;

  rx_state_e state_q, state_d;

  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [5:0]       shift_q, shift_d;   // first three dibits of the byte in progress
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             crs_low_q, crs_low_d; // previous DATA sample had CRS low

  logic [7:0]       rx_data_d;
  logic             rx_valid_d, rx_sof_d, rx_eof_d;
  logic [LEN_W-1:0] rx_len_d;
  logic             rx_crc_ok_d, rx_len_err_d, rx_align_err_d;

  logic        crc_init, crc_en;
  logic [31:0] crc;

  logic sfd_ok;
  logic frame_end;

  // CRS comes out of reset as "carrier present" so WAIT_IDLE must see a real
  // low from the PHY before re-arming, even if reset hits mid-frame.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      crs_q <= 1'b1;
      dib_q <= 2'b00;
    end else begin
      crs_q <= CRS;
      dib_q <= {RX1, RX0};
    end
  end

  assign sfd_ok = crs_q && (dib_q == SFD_DIBIT) && (pre_cnt_q >= MIN_PRE);

  // CRS low at a byte boundary ends the frame; low off-boundary is CRS_DV
  // toggling unless the previous sample was low too.
  assign frame_end = !crs_q && ((idx_q == 2'd0) || crs_low_q);

  crc32_d2 u_crc (
    .clk   (clk_50MHz),
    .rst   (rst),
    .init  (crc_init),
    .en    (crc_en),
    .dibit (dib_q),
    .crc   (crc)
  );

  // State register
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= StWaitIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitIdle: begin
        if (!crs_q) state_d = StIdle;
      end
      StIdle: begin
        if (crs_q) begin
          if (dib_q == PREAMBLE_DIBIT) begin
            state_d = StPreamble;
          end else if (dib_q != PREDATA_DIBIT) begin
            state_d = StWaitIdle;  // false carrier
          end
        end
      end
      StPreamble: begin
        if (sfd_ok) begin
          state_d = StData;
        end else if (!crs_q || (dib_q != PREAMBLE_DIBIT)) begin
          state_d = StWaitIdle;
        end
      end
      StData: begin
        if (frame_end) state_d = StIdle;
      end
      default: state_d = StWaitIdle;
    endcase
  end

  // Datapath and outputs
  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    len_d          = len_q;
    first_d        = first_q;
    crs_low_d      = crs_low_q;
    rx_data_d      = rx_data;
    rx_valid_d     = 1'b0;
    rx_sof_d       = 1'b0;
    rx_eof_d       = 1'b0;
    rx_len_d       = '0;
    rx_crc_ok_d    = 1'b0;
    rx_len_err_d   = 1'b0;
    rx_align_err_d = 1'b0;
    crc_init       = 1'b0;
    crc_en         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (crs_q && (dib_q == PREAMBLE_DIBIT)) pre_cnt_d = 8'd1;
      end
      StPreamble: begin
        if (crs_q && (dib_q == PREAMBLE_DIBIT) && (pre_cnt_q != 8'hFF)) begin
          pre_cnt_d = pre_cnt_q + 8'd1;
        end
        if (sfd_ok) begin
          crc_init  = 1'b1;
          idx_d     = 2'd0;
          len_d     = '0;
          first_d   = 1'b1;
          crs_low_d = 1'b0;
        end
      end
      StData: begin
        if (frame_end) begin
          rx_eof_d       = 1'b1;
          rx_len_d       = len_q;
          rx_crc_ok_d    = (crc == CRC32_RESIDUE);
          rx_len_err_d   = (len_q < MIN_LEN) || (len_q > MAX_LEN);
          rx_align_err_d = (idx_q != 2'd0);
        end else begin
          crc_en    = 1'b1;
          shift_d   = {dib_q, shift_q[5:2]};
          idx_d     = idx_q + 2'd1;
          crs_low_d = !crs_q;
          if (idx_q == 2'd3) begin
            rx_data_d  = {dib_q, shift_q};
            rx_valid_d = 1'b1;
            rx_sof_d   = first_q;
            first_d    = 1'b0;
            if (len_q != LEN_SAT) len_d = len_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      first_q      <= 1'b0;
      crs_low_q    <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_len       <= '0;
      rx_crc_ok    <= 1'b0;
      rx_len_err   <= 1'b0;
      rx_align_err <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      first_q      <= first_d;
      crs_low_q    <= crs_low_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      rx_sof       <= rx_sof_d;
      rx_eof       <= rx_eof_d;
      rx_len       <= rx_len_d;
      rx_crc_ok    <= rx_crc_ok_d;
      rx_len_err   <= rx_len_err_d;
      rx_align_err <= rx_align_err_d;
    end
  end

endmodule

// File: tb/tb_rmii_rx_mac.sv
// Directed testbench for rmii_rx_mac. Frames are built with a byte-wise
// reference CRC-32; a negedge collector records delivered bytes and EOF status.
module tb_rmii_rx_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CRS = 1'b0;
  logic        RX0 = 1'b0;
  logic        RX1 = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic [10:0] rx_len;
  logic        rx_crc_ok, rx_len_err, rx_align_err;

  int checks = 0;
  int errors = 0;

  rmii_rx_mac dut (
    .clk_50MHz    (clk),
    .rst          (rst),
    .CRS          (CRS),
    .RX0          (RX0),
    .RX1          (RX1),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_len       (rx_len),
    .rx_crc_ok    (rx_crc_ok),
    .rx_len_err   (rx_len_err),
    .rx_align_err (rx_align_err)
  );

  always #10 clk = ~clk;

  // Collector
  logic [7:0] cap [0:4095];
  int nbytes = 0, nsof = 0, sof_pos = -1, neof = 0;
  int e_len = 0, e_crc = 0, e_lerr = 0, e_align = 0;
  int ncoinc = 0, nconsec = 0, nstray_sof = 0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (nbytes < 4096) cap[nbytes] = rx_data;
      if (rx_sof) begin
        nsof++;
        sof_pos = nbytes;
      end
      nbytes++;
    end else if (rx_sof) begin
      nstray_sof++;
    end
    if (rx_eof) begin
      neof++;
      e_len   = int'(rx_len);
      e_crc   = int'(rx_crc_ok);
      e_lerr  = int'(rx_len_err);
      e_align = int'(rx_align_err);
    end
    if (rx_valid && rx_eof) ncoinc++;
    if (rx_valid && prev_valid) nconsec++;
    prev_valid = rx_valid;
  end

  logic [7:0] frame [0:2047];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Payload bytes are index mod 256; last four bytes are the FCS, LSB first.
  task automatic build_frame(input int n, input bit bad_fcs);
    logic [31:0] c, fcs;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      frame[i] = 8'(i);
      c = ref_crc_byte(c, frame[i]);
    end
    fcs = bad_fcs ? 32'hABCD_EF22 : ~c;
    for (int j = 0; j < 4; j++) frame[n-4+j] = fcs[8*j +: 8];
  endtask

  task automatic send_dibit(input logic crs, input logic [1:0] d);
    @(negedge clk);
    CRS = crs;
    RX1 = d[1];
    RX0 = d[0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_dibit(1'b0, 2'b00);
  endtask

  task automatic send_frame(input int n, input bit toggle, input int extra, input int npre);
    for (int i = 0; i < npre; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b11);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 4; k++) begin
        send_dibit(!(toggle && (b >= n - 10) && (k == 2)), frame[b][2*k +: 2]);
      end
    end
    for (int i = 0; i < extra; i++) send_dibit(1'b1, 2'b10);
    idle(12);
  endtask

  function automatic int data_mism(input int base, input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++) if (cap[(base + i) % 4096] !== frame[i]) m++;
    return m;
  endfunction

  int b0, e0, s0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_eof", int'(rx_eof), 0);
    chk("reset_status", int'({rx_sof, rx_crc_ok, rx_len_err, rx_align_err}), 0);
    chk("reset_data_len", int'({rx_data, rx_len}), 0);
    rst = 1'b0;
    idle(6);

    // Good 64-byte frame
    build_frame(64, 1'b0);
    b0 = nbytes; e0 = neof; s0 = nsof;
    send_frame(64, 1'b0, 0, 35);
    chk("f64_bytes", nbytes - b0, 64);
    chk("f64_data", data_mism(b0, 64), 0);
    chk("f64_sof_cnt", nsof - s0, 1);
    chk("f64_sof_pos", sof_pos, b0);
    chk("f64_eof_cnt", neof - e0, 1);
    chk("f64_len", e_len, 64);
    chk("f64_crc_ok", e_crc, 1);
    chk("f64_len_err", e_lerr, 0);
    chk("f64_align", e_align, 0);

    // Bad FCS
    build_frame(64, 1'b1);
    b0 = nbytes; e0 = neof;
    send_frame(64, 1'b0, 0, 35);
    chk("badfcs_bytes", nbytes - b0, 64);
    chk("badfcs_data", data_mism(b0, 64), 0);
    chk("badfcs_eof_cnt", neof - e0, 1);
    chk("badfcs_crc_ok", e_crc, 0);
    chk("badfcs_len", e_len, 64);

    // Runt frame, correct CRC
    build_frame(60, 1'b0);
    b0 = nbytes; e0 = neof;
    send_frame(60, 1'b0, 0, 35);
    chk("runt_eof_cnt", neof - e0, 1);
    chk("runt_len", e_len, 60);
    chk("runt_len_err", e_lerr, 1);
    chk("runt_crc_ok", e_crc, 1);

    // Oversize frame
    build_frame(1519, 1'b0);
    b0 = nbytes; e0 = neof;
    send_frame(1519, 1'b0, 0, 35);
    chk("big_bytes", nbytes - b0, 1519);
    chk("big_data", data_mism(b0, 1519), 0);
    chk("big_len", e_len, 1519);
    chk("big_len_err", e_lerr, 1);
    chk("big_crc_ok", e_crc, 1);

    // CRS_DV toggling in the last 10 bytes
    build_frame(64, 1'b0);
    b0 = nbytes; e0 = neof;
    send_frame(64, 1'b1, 0, 35);
    chk("tog_bytes", nbytes - b0, 64);
    chk("tog_data", data_mism(b0, 64), 0);
    chk("tog_eof_cnt", neof - e0, 1);
    chk("tog_align", e_align, 0);
    chk("tog_crc_ok", e_crc, 1);
    chk("tog_len", e_len, 64);

    // One extra dibit after the frame
    b0 = nbytes; e0 = neof;
    send_frame(64, 1'b0, 1, 35);
    chk("align_bytes", nbytes - b0, 64);
    chk("align_eof_cnt", neof - e0, 1);
    chk("align_err", e_align, 1);
    chk("align_len", e_len, 64);

    // Reset mid-DATA with CRS held high
    for (int i = 0; i < 35; i++) send_dibit(1'b1, 2'b01);
    send_dibit(1'b1, 2'b11);
    for (int b = 0; b < 20; b++)
      for (int k = 0; k < 4; k++) send_dibit(1'b1, frame[b][2*k +: 2]);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) send_dibit(1'b1, frame[20][2*k +: 2]);
    rst = 1'b0;
    b0 = nbytes; e0 = neof;
    for (int b = 21; b < 64; b++)
      for (int k = 0; k < 4; k++) send_dibit(1'b1, frame[b][2*k +: 2]);
    idle(12);
    chk("rst_no_bytes", nbytes - b0, 0);
    chk("rst_no_eof", neof - e0, 0);
    b0 = nbytes; e0 = neof;
    send_frame(64, 1'b0, 0, 35);
    chk("rst_fresh_bytes", nbytes - b0, 64);
    chk("rst_fresh_data", data_mism(b0, 64), 0);
    chk("rst_fresh_crc_ok", e_crc, 1);

    // False carrier followed by a frame under the same carrier
    b0 = nbytes; e0 = neof;
    send_dibit(1'b1, 2'b10);
    send_dibit(1'b1, 2'b10);
    send_frame(64, 1'b0, 0, 35);
    chk("fc_no_bytes", nbytes - b0, 0);
    chk("fc_no_eof", neof - e0, 0);

    // Preamble shorter than the minimum
    b0 = nbytes; e0 = neof;
    send_frame(64, 1'b0, 0, 4);
    chk("shortpre_no_bytes", nbytes - b0, 0);
    chk("shortpre_no_eof", neof - e0, 0);

    // Stream-wide properties
    chk("eof_with_valid", ncoinc, 0);
    chk("valid_back_to_back", nconsec, 0);
    chk("sof_without_valid", nstray_sof, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmii_rx_mac.md
Name: rmii_rx_mac

Overview:
RMII receive-side MAC front end for 100 Mb/s operation. Consumes CRS_DV and RXD[1:0] from the PHY on the 50 MHz reference clock, strips preamble/SFD, assembles bytes, and checks FCS and length. Delivers a byte stream with SOF/EOF strobes and per-frame status to the downstream IP/UDP parser. It is the receive counterpart to the existing RMII frame transmitter.

Parameters:
MIN_PREAMBLE_DIBITS, 8, minimum count of consecutive 2'b01 dibits required before the SFD dibit 2'b11.
MIN_FRAME_BYTES, 64, minimum legal frame length (DA through FCS).
MAX_FRAME_BYTES, 1518, maximum legal frame length; the byte counter saturates at 2047.

Ports:
clk_50MHz  in  1  RMII reference clock; the only clock in the block.
rst  in  1  synchronous, active-high reset.
CRS  in  1  RMII CRS_DV from the PHY.
RX0  in  1  RXD[0]; LSB of each dibit.
RX1  in  1  RXD[1].
rx_data  out  8  received byte; the first dibit occupies bits [1:0].
rx_valid  out  1  one-cycle strobe; rx_data is valid.
rx_sof  out  1  high together with rx_valid on the first byte after the SFD.
rx_eof  out  1  one-cycle end-of-frame strobe, never coincident with rx_valid.
rx_len  out  11  frame byte count including FCS; valid while rx_eof is high.
rx_crc_ok  out  1  FCS residue matched; valid while rx_eof is high.
rx_len_err  out  1  rx_len < MIN_FRAME_BYTES or rx_len > MAX_FRAME_BYTES; valid while rx_eof is high.
rx_align_err  out  1  frame ended on a non-byte boundary; valid while rx_eof is high.

Behaviour:
- Inputs:
  - CRS, RX0 and RX1 are registered once; all logic below operates on the registered copies.
  - Dibit d = {RX1, RX0}.
- Reset:
  - Every output is 0 and the state is WAIT_IDLE.
  - Reset mid-frame abandons the frame with no rx_eof.
- States:
  - WAIT_IDLE: stay until CRS=0, then go to IDLE. This prevents joining a frame mid-stream after reset or an error.
  - IDLE: on CRS=1 with d=00, stay (PHY pre-data). On CRS=1 with d=01, go to PREAMBLE with the count set to 1. Any other dibit with CRS=1 is a false carrier and goes to WAIT_IDLE.
  - PREAMBLE: on d=01, increment the count. On d=11 with count >= MIN_PREAMBLE_DIBITS, go to DATA; this is the SFD 0xD5. On d=11 with a short count, any other dibit, or CRS=0, go to WAIT_IDLE with no outputs.
  - DATA: shift dibits into the byte register; the dibit index runs 0..3 and wraps. Each completed byte updates rx_len and rx_crc.
- Byte output:
  - rx_valid is high exactly one cycle, two clocks after the 4th dibit of a byte is present on the pins.
  - Throughput is one byte per 4 clocks; rx_valid is never high on consecutive cycles.
- End of frame:
  - Detected in DATA when CRS=0 is sampled at dibit index 0 (byte boundary).
  - CRS=0 sampled at index 1..3 is treated as RMII CRS_DV toggling. The dibit is still taken as data and the frame continues.
  - Two consecutive CRS=0 samples where the second falls at index 1..3 also end the frame, with rx_align_err=1 and the partial byte discarded.
  - rx_eof is pulsed 2 clocks after the terminating sample, with all four status outputs registered alongside it; the state then returns to IDLE.
- CRC:
  - CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF on SFD.
  - Updated per dibit, LSB first, over DA through FCS.
  - rx_crc_ok=1 when the register equals the residue 0xC704DD7B at EOF (or 0xDEBB20E3 if the bit-reversed/complemented form is kept; pick one and document it in the package).
- Length:
  - rx_len counts bytes from DA through FCS and saturates at 2047.
  - Overflow beyond MAX_FRAME_BYTES continues streaming bytes but sets rx_len_err.
- Frames and bytes:
  - No frame without a completed SFD produces any output.
  - rx_sof marks the first byte only.

Decomposition:
- Shared package eth_pkg:
  - preamble dibit 2'b01, SFD dibit 2'b11
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE
  - ETH_MIN_FRAME, ETH_MAX_FRAME
  - the rx state enum
- Sub-module crc32_d2: a combinational next-CRC from the current CRC and one dibit, plus a registered state with init/enable.
  - The transmitter is to reuse it later to replace its fixed FCS.

Test Plan:
- 8×0x55 + 0xD5, then bytes 0x00..0x3B, then correct FCS -> 64 rx_valid pulses, data 0x00..0x3B then FCS, rx_sof on byte 0x00, rx_eof with rx_len=64, rx_crc_ok=1, no errors.
- Same frame with FCS replaced by 0xABCDEF22 -> 64 bytes delivered, rx_eof with rx_crc_ok=0, rx_len=64.
- 60-byte frame (incl. FCS, correct CRC) -> rx_len=60, rx_len_err=1, rx_crc_ok=1; a 1519-byte frame -> rx_len=1519, rx_len_err=1.
- CRS_DV toggled low at dibit index 2 of every byte in the last 10 bytes -> byte stream identical to the untoggled case, no align error.
- Frame ending after 1 extra dibit -> rx_align_err=1, rx_len excludes the partial byte.
- rst pulsed mid-DATA with CRS held high -> no rx_eof, no rx_valid until CRS drops and a fresh preamble+SFD arrives. False carrier (CRS=1, d=10) -> no output.
